// File: rtl/wb_scoreboard_pkg.sv
// Shared types and helpers for the writeback scoreboard: FSM state encoding,
// index-width derivation and write-enable population count.
package wb_scoreboard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned POP_W = 6;

  // Index width for n entries, never below one bit
  function automatic int unsigned aw_of(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [POP_W-1:0] popcount(input logic [31:0] v);
    logic [POP_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < 32; i++) cnt = cnt + POP_W'(v[i]);
    return cnt;
  endfunction

endpackage

// File: rtl/wb_trace_fifo.sv
// Circular trace buffer of {addr,data} entries; a push into a full buffer
// overwrites the oldest entry and raises the sticky overflow flag.
module wb_trace_fifo
  import wb_scoreboard_pkg::*;
#(
  parameter int unsigned AW     = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned PW    = aw_of(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic [AW-1:0]     push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              drop,
  input  logic              pop,
  output logic              valid,
  output logic [AW-1:0]     head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              ovf
);

  logic [AW-1:0]     mem_addr_q [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PW:0]       count_q, count_d;
  logic              valid_q, ovf_q;
  logic              do_pop, full, overwrite;

  assign full = (count_q == (PW+1)'(DEPTH));

  always_comb begin
    do_pop    = pop && valid_q;
    overwrite = push && full && !do_pop;
    count_d   = count_q;
    if (push && !do_pop && !full) count_d = count_q + (PW+1)'(1);
    else if (!push && do_pop)     count_d = count_q - (PW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop || overwrite) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
      valid_q <= (count_d != '0);
      if (overwrite || drop) ovf_q <= 1'b1;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr_q[wr_ptr_q] <= push_addr;
      mem_data_q[wr_ptr_q] <= push_data;
    end
  end

  assign valid     = valid_q;
  assign ovf       = ovf_q;
  assign head_addr = mem_addr_q[rd_ptr_q];
  assign head_data = mem_data_q[rd_ptr_q];

endmodule

// File: rtl/wb_scoreboard.sv
// Writeback scoreboard: snoops NWP regfile write ports into a shadow file, runs a
// watchdog, then compares the shadow against a preloaded expected table.
// Optional write trace FIFO enabled by defining WB_TRACE_EN.
module wb_scoreboard
  import wb_scoreboard_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NREGS       = 16,
  parameter int unsigned NWP         = 2,
  parameter int unsigned TIMEOUT     = 2500,
  parameter int unsigned TRACE_DEPTH = 8,
  localparam int unsigned AW         = aw_of(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  halt,
  input  logic [NWP-1:0]        we,
  input  logic [NWP*AW-1:0]     wa,
  input  logic [NWP*DATA_W-1:0] wd,
  input  logic                  exp_we,
  input  logic [AW-1:0]         exp_addr,
  input  logic [DATA_W-1:0]     exp_data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [AW-1:0]         mism_reg,
  output logic [DATA_W-1:0]     mism_got,
  output logic [31:0]           wb_count,
  output logic                  tr_valid,
  input  logic                  tr_ready,
  output logic [AW-1:0]         tr_addr,
  output logic [DATA_W-1:0]     tr_data,
  output logic                  tr_ovf
);

  localparam int unsigned WD_W = $clog2(TIMEOUT) + 1;

  state_e            state_q;
  logic              busy_q, done_q, pass_q, timeout_q;
  logic [AW-1:0]     mism_reg_q, idx_q;
  logic [DATA_W-1:0] mism_got_q;
  logic [31:0]       wb_count_q, wb_count_d;
  logic [WD_W-1:0]   wdog_q;
  logic [DATA_W-1:0] shadow_q [NREGS];
  logic [DATA_W-1:0] exp_q    [NREGS];
  logic [NREGS-1:0]  exp_vld_q;
  logic [32:0]       wb_sum;
  logic              run_start, in_run, chk_mism, chk_last;

  assign run_start = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign in_run    = (state_q == ST_RUN);
  assign chk_mism  = exp_vld_q[idx_q] && (shadow_q[idx_q] != exp_q[idx_q]);
  assign chk_last  = (idx_q == AW'(NREGS - 1));

  // Saturating retired-write counter
  assign wb_sum     = {1'b0, wb_count_q} + 33'(popcount(32'(we)));
  assign wb_count_d = wb_sum[32] ? 32'hFFFF_FFFF : wb_sum[31:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      mism_reg_q <= '0;
      mism_got_q <= '0;
      wb_count_q <= '0;
      wdog_q     <= '0;
      idx_q      <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q    <= ST_RUN;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
            mism_reg_q <= '0;
            mism_got_q <= '0;
            wb_count_q <= '0;
            wdog_q     <= '0;
            idx_q      <= '0;
          end
        end
        ST_RUN: begin
          wb_count_q <= wb_count_d;
          wdog_q     <= wdog_q + WD_W'(1);
          // halt takes priority over a same-cycle watchdog expiry
          if (halt) begin
            state_q <= ST_CHECK;
          end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
            state_q   <= ST_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
            pass_q    <= 1'b0;
          end
        end
        ST_CHECK: begin
          if (chk_mism) begin
            state_q    <= ST_DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            pass_q     <= 1'b0;
            mism_reg_q <= idx_q;
            mism_got_q <= shadow_q[idx_q];
          end else if (chk_last) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= 1'b1;
          end else begin
            idx_q <= idx_q + AW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Shadow file; later ports override earlier ones on an address collision
  always_ff @(posedge clk) begin
    if (reset || run_start) begin
      for (int r = 0; r < NREGS; r++) shadow_q[r] <= '0;
    end else if (in_run) begin
      for (int p = 0; p < NWP; p++) begin
        if (we[p]) shadow_q[wa[p*AW +: AW]] <= wd[p*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) exp_vld_q <= '0;
    else if (exp_we && state_q == ST_IDLE) exp_vld_q[exp_addr] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (exp_we && state_q == ST_IDLE) exp_q[exp_addr] <= exp_data;
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign timeout  = timeout_q;
  assign mism_reg = mism_reg_q;
  assign mism_got = mism_got_q;
  assign wb_count = wb_count_q;

`ifdef WB_TRACE_EN
  logic              tr_push, tr_drop;
  logic [AW-1:0]     tr_push_addr;
  logic [DATA_W-1:0] tr_push_data;

  // Lowest enabled port is traced; any other enabled port that cycle is dropped
  always_comb begin
    tr_push      = 1'b0;
    tr_drop      = 1'b0;
    tr_push_addr = '0;
    tr_push_data = '0;
    if (in_run) begin
      for (int p = 0; p < NWP; p++) begin
        if (we[p]) begin
          if (tr_push) begin
            tr_drop = 1'b1;
          end else begin
            tr_push      = 1'b1;
            tr_push_addr = wa[p*AW +: AW];
            tr_push_data = wd[p*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  wb_trace_fifo #(
    .AW     (AW),
    .DATA_W (DATA_W),
    .DEPTH  (TRACE_DEPTH)
  ) u_trace (
    .clk       (clk),
    .reset     (reset),
    .clear     (run_start),
    .push      (tr_push),
    .push_addr (tr_push_addr),
    .push_data (tr_push_data),
    .drop      (tr_drop),
    .pop       (tr_ready),
    .valid     (tr_valid),
    .head_addr (tr_addr),
    .head_data (tr_data),
    .ovf       (tr_ovf)
  );
`else
  localparam int unsigned unused_trace_depth = TRACE_DEPTH;
  logic unused_tr_ready;

  assign unused_tr_ready = tr_ready;
  assign tr_valid        = 1'b0;
  assign tr_addr         = '0;
  assign tr_data         = '0;
  assign tr_ovf          = 1'b0;
`endif

endmodule

// File: tb/tb_wb_scoreboard.sv
// Self-checking bench for wb_scoreboard: directed scenarios plus randomized runs
// checked against a plain array model of the shadow file and expected table.
module tb_wb_scoreboard;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned NREGS       = 16;
  localparam int unsigned NWP         = 2;
  localparam int unsigned TIMEOUT     = 2500;
  localparam int unsigned TRACE_DEPTH = 8;
  localparam int unsigned AW          = 4;
  localparam int unsigned NCYC        = 24;

  logic                  clk = 1'b0;
  logic                  reset, start, halt, exp_we, tr_ready;
  logic [NWP-1:0]        we;
  logic [NWP*AW-1:0]     wa;
  logic [NWP*DATA_W-1:0] wd;
  logic [AW-1:0]         exp_addr;
  logic [DATA_W-1:0]     exp_data;
  logic                  busy, done, pass, timeout, tr_valid, tr_ovf;
  logic [AW-1:0]         mism_reg, tr_addr;
  logic [DATA_W-1:0]     mism_got, tr_data;
  logic [31:0]           wb_count;

  always #5 clk = ~clk;

  wb_scoreboard #(
    .DATA_W(DATA_W), .NREGS(NREGS), .NWP(NWP), .TIMEOUT(TIMEOUT), .TRACE_DEPTH(TRACE_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt),
    .we(we), .wa(wa), .wd(wd),
    .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .mism_reg(mism_reg), .mism_got(mism_got), .wb_count(wb_count),
    .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_addr(tr_addr),
    .tr_data(tr_data), .tr_ovf(tr_ovf)
  );

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  // Reference model
  logic [DATA_W-1:0] m_shadow [NREGS];
  logic [DATA_W-1:0] m_exp    [NREGS];
  bit                m_vld    [NREGS];
  longint unsigned   m_count;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_clear_all();
    for (int r = 0; r < NREGS; r++) begin
      m_shadow[r] = '0;
      m_vld[r]    = 1'b0;
    end
    m_count = 0;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_clear_all();
  endtask

  task automatic load_exp(input int a, input logic [DATA_W-1:0] d);
    exp_we   = 1'b1;
    exp_addr = AW'(a);
    exp_data = d;
    tick();
    exp_we   = 1'b0;
    m_exp[a] = d;
    m_vld[a] = 1'b1;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 0; r < NREGS; r++) m_shadow[r] = '0;
    m_count = 0;
  endtask

  task automatic wr(input logic [1:0] w, input int a0, input logic [DATA_W-1:0] d0,
                    input int a1, input logic [DATA_W-1:0] d1, input logic h);
    we   = w;
    wa   = {AW'(a1), AW'(a0)};
    wd   = {d1, d0};
    halt = h;
    tick();
    we   = '0;
    halt = 1'b0;
    if (w[0]) m_shadow[a0] = d0;
    if (w[1]) m_shadow[a1] = d1;
    m_count += w[0] + w[1];
  endtask

  // Called right after the halt cycle: waits out CHECK and compares results
  task automatic finish_run(input string tag);
    int first;
    int n;
    int exp_cycles;
    first = -1;
    for (int r = 0; r < NREGS; r++) begin
      if (first < 0 && m_vld[r] && m_shadow[r] != m_exp[r]) first = r;
    end
    exp_cycles = (first < 0) ? NREGS : first + 1;
    n = 0;
    while (done !== 1'b1 && n < NREGS + 8) begin
      tick();
      n++;
    end
    check({tag, "_cycles"}, 64'(n), 64'(exp_cycles));
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_pass"}, 64'(pass), (first < 0) ? 64'd1 : 64'd0);
    check({tag, "_timeout"}, 64'(timeout), 64'd0);
    check({tag, "_mism_reg"}, 64'(mism_reg), (first < 0) ? 64'd0 : 64'(first));
    check({tag, "_mism_got"}, 64'(mism_got), (first < 0) ? 64'd0 : 64'(m_shadow[first]));
    check({tag, "_wb_count"}, 64'(wb_count), 64'(m_count));
  endtask

  task automatic random_run(input string tag, input bit corrupt);
    logic [1:0]        r_we [NCYC];
    int                r_a0 [NCYC];
    int                r_a1 [NCYC];
    logic [DATA_W-1:0] r_d0 [NCYC];
    logic [DATA_W-1:0] r_d1 [NCYC];
    logic [DATA_W-1:0] fin  [NREGS];
    int c;
    for (int r = 0; r < NREGS; r++) fin[r] = '0;
    for (int i = 0; i < NCYC; i++) begin
      r_we[i] = 2'($urandom_range(3));
      r_a0[i] = $urandom_range(NREGS - 1);
      r_a1[i] = $urandom_range(NREGS - 1);
      r_d0[i] = $urandom;
      r_d1[i] = $urandom;
      if (r_we[i][0]) fin[r_a0[i]] = r_d0[i];
      if (r_we[i][1]) fin[r_a1[i]] = r_d1[i];
    end
    do_reset();
    for (int r = 0; r < NREGS; r++) if ($urandom_range(1) == 1) load_exp(r, fin[r]);
    if (corrupt) begin
      c = $urandom_range(NREGS - 1);
      load_exp(c, fin[c] ^ DATA_W'($urandom_range(255) + 1));
    end
    start_run();
    for (int i = 0; i < NCYC; i++)
      wr(r_we[i], r_a0[i], r_d0[i], r_a1[i], r_d1[i], (i == NCYC - 1));
    finish_run(tag);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; halt = 1'b0; exp_we = 1'b0; tr_ready = 1'b0;
    we = '0; wa = '0; wd = '0; exp_addr = '0; exp_data = '0;
    for (int r = 0; r < NREGS; r++) m_exp[r] = '0;
    do_reset();

    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_pass", 64'(pass), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    check("rst_wb_count", 64'(wb_count), 64'd0);
    check("rst_tr_valid", 64'(tr_valid), 64'd0);

    // Single matching write
    load_exp(0, 32'd10);
    start_run();
    check("run_busy", 64'(busy), 64'd1);
    wr(2'b01, 0, 32'd10, 0, '0, 1'b0);
    wr(2'b00, 0, '0, 0, '0, 1'b1);
    finish_run("match_r0");

    // Mismatch at R3, then exp table persists and DONE ignores exp_we
    do_reset();
    load_exp(3, 32'd7);
    start_run();
    wr(2'b01, 3, 32'd5, 0, '0, 1'b1);
    finish_run("mism_r3");
    exp_we = 1'b1; exp_addr = 4'd3; exp_data = 32'd5;
    tick();
    exp_we = 1'b0;
    start_run();
    wr(2'b01, 3, 32'd5, 0, '0, 1'b1);
    finish_run("persist_r3");

    // Same-address collision: higher port wins; start/exp_we during RUN ignored
    do_reset();
    load_exp(2, 32'd9);
    start_run();
    wr(2'b11, 2, 32'd1, 2, 32'd9, 1'b0);
    start = 1'b1; exp_we = 1'b1; exp_addr = 4'd2; exp_data = 32'd1;
    tick();
    start = 1'b0; exp_we = 1'b0;
    wr(2'b00, 0, '0, 0, '0, 1'b1);
    finish_run("collide_r2");
`ifndef WB_TRACE_EN
    check("notrace_valid", 64'(tr_valid), 64'd0);
    check("notrace_ovf", 64'(tr_ovf), 64'd0);
`endif

    // Watchdog expiry exactly TIMEOUT cycles after RUN entry
    do_reset();
    start_run();
    n = 0;
    while (done !== 1'b1 && n < TIMEOUT + 20) begin
      tick();
      n++;
    end
    check("wdog_cycles", 64'(n), 64'(TIMEOUT));
    check("wdog_timeout", 64'(timeout), 64'd1);
    check("wdog_pass", 64'(pass), 64'd0);
    check("wdog_busy", 64'(busy), 64'd0);

    // Halt on the expiry cycle wins
    do_reset();
    start_run();
    repeat (TIMEOUT - 1) tick();
    wr(2'b00, 0, '0, 0, '0, 1'b1);
    check("hvw_busy", 64'(busy), 64'd1);
    check("hvw_done", 64'(done), 64'd0);
    finish_run("hvw");

    // Reset in the middle of CHECK aborts and clears the expected-valid bits
    do_reset();
    load_exp(5, 32'd1);
    start_run();
    wr(2'b00, 0, '0, 0, '0, 1'b1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_clear_all();
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_pass", 64'(pass), 64'd0);
    start_run();
    wr(2'b01, 5, 32'd2, 0, '0, 1'b1);
    finish_run("midrst_run");

    for (int k = 0; k < 6; k++) random_run($sformatf("rand%0d", k), (k % 2) == 1);

`ifdef WB_TRACE_EN
    // Ten single-port writes into an eight-entry trace, then drain it
    do_reset();
    start_run();
    for (int i = 0; i < 10; i++) wr(2'b01, i, DATA_W'(100 + i), 0, '0, 1'b0);
    check("tr_ovf", 64'(tr_ovf), 64'd1);
    check("tr_valid_full", 64'(tr_valid), 64'd1);
    tr_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("tr_addr%0d", k), 64'(tr_addr), 64'(k + 2));
      check($sformatf("tr_data%0d", k), 64'(tr_data), 64'(102 + k));
      tick();
    end
    tr_ready = 1'b0;
    check("tr_valid_empty", 64'(tr_valid), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
